// File: rtl/hazard_scoreboard_if.sv
// Forwarding-producer bundle between the ID stage and the hazard scoreboard.
// master = ID-stage driver, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_kill;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_RegWrite;
    logic             id_MemRead;
    logic [2:0]       id_NPCOp;
    logic [4:0]       ID_EX_rd;
    logic [4:0]       EX_MEM_rd;
    logic [4:0]       MEM_WB_rd;
    logic             ID_EX_RegWrite;
    logic             EX_MEM_RegWrite;
    logic             MEM_WB_RegWrite;
    logic             ID_EX_MemRead;
    logic             EX_MEM_MemRead;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_kill, id_rs1, id_rs2,
        output id_use_rs1, id_use_rs2, id_rd,
        output id_RegWrite, id_MemRead, id_NPCOp,
        input  ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
        input  ID_EX_RegWrite, EX_MEM_RegWrite,
        input  MEM_WB_RegWrite,
        input  ID_EX_MemRead, EX_MEM_MemRead,
        input  stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_kill, id_rs1, id_rs2,
        input  id_use_rs1, id_use_rs2, id_rd,
        input  id_RegWrite, id_MemRead, id_NPCOp,
        output ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
        output ID_EX_RegWrite, EX_MEM_RegWrite,
        output MEM_WB_RegWrite,
        output ID_EX_MemRead, EX_MEM_MemRead,
        output stall, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destinations ID/EX..MEM/WB and raises the
// load-use / branch-operand stall that forwarding cannot cover.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);
    typedef struct packed {
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
    } entry_t;

    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    entry_t           idEx;
    entry_t           exMem;
    entry_t           memWb;
    entry_t           idEntry;
    logic [CNT_W-1:0] cnt;

    logic isBranch;
    logic exHit;
    logic memHit;
    logic loadUse;
    logic brEx;
    logic brLd;
    logic stall;
    logic bubble;

    always_comb begin
        idEntry.rd       = bus.id_rd;
        idEntry.regWrite = bus.id_RegWrite && (bus.id_rd != 5'd0);
        idEntry.memRead  = bus.id_MemRead;
    end

    assign isBranch = (bus.id_NPCOp == NPC_BRANCH) ||
                      (bus.id_NPCOp == NPC_JUMP)   ||
                      (bus.id_NPCOp == NPC_JALR);

    // rd==0 entries never carry regWrite, so x0 cannot match.
    assign exHit =
        idEx.regWrite &&
        ((bus.id_use_rs1 && idEx.rd == bus.id_rs1) ||
         (bus.id_use_rs2 && idEx.rd == bus.id_rs2));

    assign memHit =
        exMem.regWrite &&
        ((bus.id_use_rs1 && exMem.rd == bus.id_rs1) ||
         (bus.id_use_rs2 && exMem.rd == bus.id_rs2));

    assign loadUse = exHit && idEx.memRead;
    assign brEx    = isBranch && exHit;
    assign brLd    = isBranch && memHit && exMem.memRead;

    assign stall  = bus.id_valid && !bus.id_kill &&
                    (loadUse || brEx || brLd);
    assign bubble = stall || bus.id_kill || !bus.id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idEx  <= '0;
            exMem <= '0;
            memWb <= '0;
            cnt   <= '0;
        end else begin
            memWb <= exMem;
            exMem <= idEx;
            idEx  <= bubble ? entry_t'('0) : idEntry;
            if (stall && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.ID_EX_rd        = idEx.rd;
    assign bus.ID_EX_RegWrite  = idEx.regWrite;
    assign bus.ID_EX_MemRead   = idEx.memRead;
    assign bus.EX_MEM_rd       = exMem.rd;
    assign bus.EX_MEM_RegWrite = exMem.regWrite;
    assign bus.EX_MEM_MemRead  = exMem.memRead;
    assign bus.MEM_WB_rd       = memWb.rd;
    assign bus.MEM_WB_RegWrite = memWb.regWrite;
    assign bus.stall           = stall;
    assign bus.stall_cnt       = cnt;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks the destination register of every in-flight instruction from ID/EX through MEM/WB and produces the `EX_MEM_rd`/`MEM_WB_rd`/`*_RegWrite` values consumed by the forwarding unit. It also generates the pipeline stall that forwarding cannot cover:
- load-use hazards;
- ID-stage branch/jump operand hazards.

It sits beside the ID stage and is the producer side of the forwarding interface.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `id_valid`  in  1  — ID holds a real instruction.
- `id_kill`  in  1  — instruction in ID is squashed this cycle (redirect).
- `id_rs1`, `id_rs2`  in  5 each  — ID source registers.
- `id_use_rs1`, `id_use_rs2`  in  1 each  — instruction actually reads that source.
- `id_rd`  in  5  — ID destination register.
- `id_RegWrite`  in  1  — ID instruction writes `rd`.
- `id_MemRead`  in  1  — ID instruction is a load.
- `id_NPCOp`  in  3  — NPC op from ctrl_encode_def.v: `NPC_PLUS4`=000, `NPC_BRANCH`=001, `NPC_JUMP`=010, `NPC_JALR`=100.
- `ID_EX_rd`, `EX_MEM_rd`, `MEM_WB_rd`  out  5 each  — registered destination per stage.
- `ID_EX_RegWrite`, `EX_MEM_RegWrite`, `MEM_WB_RegWrite`  out  1 each.
- `ID_EX_MemRead`, `EX_MEM_MemRead`  out  1 each.
- `stall`  out  1  — hold PC and IF/ID; insert bubble into ID/EX.
- `stall_cnt`  out  `CNT_W`  — total stall cycles since reset, saturating.

## Operation
**Stage entries.** Each stage entry is {rd, RegWrite, MemRead}.
- On capture, RegWrite is forced to 0 when rd == 0.
- A bubble is {0, 0, 0}.

**Branch-class.** ID is branch-class when `id_NPCOp` ∈ {`NPC_BRANCH`, `NPC_JALR`, `NPC_JUMP`}.

**Source match.** match_X(s) = X.RegWrite && X.rd == id_rsN && id_use_rsN, for stage X and source N.

**Hazard terms (combinational, any source):**
- load_use: match_ID_EX && ID_EX.MemRead.
- br_ex: branch-class && match_ID_EX. The value is not yet computed, because branch forwarding taps EX/MEM and MEM/WB only.
- br_ld: branch-class && match_EX_MEM && EX_MEM.MemRead. Load data is not available before MEM/WB.

**Stall.** `stall` = `id_valid` && !`id_kill` && (load_use || br_ex || br_ld).

**Per-edge update:**
- MEM_WB ← EX_MEM, always.
- EX_MEM ← ID_EX, always; the shifting never freezes.
- ID_EX ← bubble if `stall` || `id_kill` || !`id_valid`; otherwise ← the ID entry.
- `stall_cnt` increments when `stall`=1 and holds at all-ones.

**Effective stall lengths:**
- load followed by a dependent ALU op: 1 cycle.
- ALU op followed by a dependent branch: 1 cycle.
- load followed by a dependent branch: 2 cycles (br_ex, then br_ld).
- branch two slots behind a load: 1 cycle (br_ld).

No explicit FSM is used: the stall sequence emerges from the shift.

## Timing
- Reset value of every output: 0, including `stall_cnt`; the pipeline is empty.
- Reset mid-stall: all entries and `stall` clear immediately, asynchronously.
- `stall` is combinational from ID inputs and the registered state, and is valid in the same cycle.
- Shift latency:
  - an ID entry captured at edge N appears on `ID_EX_*` after N;
  - on `EX_MEM_*` after N+1;
  - on `MEM_WB_*` after N+2.
- `id_kill` and a hazard in the same cycle: `stall`=0, a bubble is inserted, and `stall_cnt` is unchanged.
- rd == 0 never causes a stall and is never reported with RegWrite=1.
- Both sources hitting different hazard terms still yield a single stall cycle per edge. The counter advances by 1.
- `stall_cnt` at all-ones stays at all-ones.

## Test plan
1. **Load-use, ALU consumer.** Apply `rst`; then `lw x5` (rd=5, MemRead=1) followed by `add` (rs1=5, use_rs1=1).
   - Required: `stall`=1 for exactly one cycle and `ID_EX_RegWrite`=0 on the bubble.
   - Next: `EX_MEM_rd`=5, `EX_MEM_MemRead`=1.
   - `stall_cnt`=1.
2. **Load then dependent branch.** `lw x6`, then `beq` (rs2=6, `NPCOp`=001).
   - Required: `stall`=1 for 2 consecutive cycles; then `MEM_WB_rd`=6 and `stall`=0.
   - `stall_cnt`=2.
3. **ALU then dependent branch or jalr.**
   - `addi x7`, then `jalr` (rs1=7, `NPCOp`=100): 1 stall cycle.
   - The same sequence with a non-branch consumer: 0 stalls.
4. **x0 and no-use.**
   - `lw x0`, then `add` reading x0: `stall`=0 and `EX_MEM_RegWrite`=0 later.
   - Load to x8, then an instruction with `id_use_rs1`=0 and rs1=8: `stall`=0.
5. **Kill versus hazard.**
   - A load-use pair with `id_kill`=1 on the consumer: `stall`=0, a bubble enters ID/EX, and `stall_cnt` is unchanged.
   - Assert `rst` while a stall is asserted: all outputs read 0 before the next edge.
6. **Counter saturation.** With `CNT_W`=4, hold a load-use hazard for 20 stall cycles (re-issue loads): `stall_cnt` stops at 15.
